fetch_sequencer: RTL and testbench

- Control-side stage directly upstream of the address register file (PC/AR/SP).
- Sequences a 16-bit instruction fetch from byte-wide memory:
  - drives PC onto the OutD address bus;
  - reads two bytes into an internal IR;
  - increments PC once per byte through the register file's RegSel/FunSel controls.
- Also performs PC reloads for branches.
- Presents the fetched instruction to the decode stage with a valid/ack handshake.

---
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its stimulus/memory side, the
// address register file controls and the decode stage.
interface fetch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Stall;
  logic [7:0]       MemData;
  logic             BranchLoad;
  logic             Ack;
  logic [2:0]       ARF_RegSel;
  logic [2:0]       ARF_FunSel;
  logic [1:0]       ARF_OutDSel;
  logic             Mem_CS;
  logic             Mem_WR;
  logic [15:0]      IR;
  logic             IRValid;
  logic             Busy;
  logic [CNT_W-1:0] FetchCount;

  modport slave (
    input  Start, Stall, MemData, BranchLoad, Ack,
    output ARF_RegSel, ARF_FunSel, ARF_OutDSel, Mem_CS, Mem_WR,
           IR, IRValid, Busy, FetchCount
  );

  modport master (
    output Start, Stall, MemData, BranchLoad, Ack,
    input  ARF_RegSel, ARF_FunSel, ARF_OutDSel, Mem_CS, Mem_WR,
           IR, IRValid, Busy, FetchCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer driving the PC/AR/SP register file
// controls, with branch reload and a valid/ack hand-off to decode.
module fetch_sequencer #(
  parameter logic [15:0] IR_RESET  = 16'h0000,
  parameter bit          LOW_FIRST = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    VALID  = 3'd3,
    BRANCH = 3'd4
  } state_e;

  localparam logic [2:0] SEL_NONE   = 3'b111;
  localparam logic [2:0] SEL_PC     = 3'b011;
  localparam logic [2:0] FUN_HOLD   = 3'b000;
  localparam logic [2:0] FUN_INC    = 3'b001;
  localparam logic [2:0] FUN_LOAD_I = 3'b010;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       reg_sel;
  logic [2:0]       fun_sel;
  logic             mem_cs_n;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      ir_q       <= IR_RESET;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  // The memory byte is captured on the same edge that the register file
  // increments PC, so each active fetch cycle consumes exactly one address.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    reg_sel  = SEL_NONE;
    fun_sel  = FUN_HOLD;
    mem_cs_n = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = FETCH1;
        end
      end

      FETCH1: begin
        if (!bus.Stall) begin
          mem_cs_n = 1'b0;
          reg_sel  = SEL_PC;
          fun_sel  = FUN_INC;
          if (LOW_FIRST) begin
            ir_d[7:0] = bus.MemData;
          end else begin
            ir_d[15:8] = bus.MemData;
          end
          state_d = FETCH2;
        end
      end

      FETCH2: begin
        if (!bus.Stall) begin
          mem_cs_n = 1'b0;
          reg_sel  = SEL_PC;
          fun_sel  = FUN_INC;
          if (LOW_FIRST) begin
            ir_d[15:8] = bus.MemData;
          end else begin
            ir_d[7:0] = bus.MemData;
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = VALID;
        end
      end

      VALID: begin
        if (bus.BranchLoad) begin
          state_d = BRANCH;
        end else if (bus.Ack) begin
          state_d = IDLE;
        end
      end

      BRANCH: begin
        reg_sel = SEL_PC;
        fun_sel = FUN_LOAD_I;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ir_valid_d = (state_d == VALID);
  end

  assign bus.ARF_RegSel  = reg_sel;
  assign bus.ARF_FunSel  = fun_sel;
  assign bus.ARF_OutDSel = 2'b00;
  assign bus.Mem_CS      = mem_cs_n;
  assign bus.Mem_WR      = 1'b0;
  assign bus.IR          = ir_q;
  assign bus.IRValid     = ir_valid_q;
  assign bus.Busy        = (state_q == FETCH1) || (state_q == FETCH2) ||
                           (state_q == BRANCH);
  assign bus.FetchCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: two instances (low-first/16-bit count
// and high-first/4-bit count) sharing a byte memory, each with its own PC model.
module tb_fetch_sequencer;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n0, rst_n1;
  logic [7:0]  mem [0:65535];
  logic [15:0] pc [2];
  logic        pc_set [2];
  logic [15:0] pc_set_val [2];
  logic [15:0] i_bus;

  logic        start [2];
  logic        stall [2];
  logic        ack [2];
  logic        brl [2];

  logic [2:0]  reg_sel [2];
  logic [2:0]  fun_sel [2];
  logic [1:0]  outd_sel [2];
  logic        mem_cs [2];
  logic        mem_wr [2];
  logic [15:0] ir [2];
  logic        ir_valid [2];
  logic        busy [2];
  logic [15:0] fc [2];
  logic        prev_valid [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks;
  int errors;

  fetch_sequencer_if #(.CNT_W(16)) bus0 ();
  fetch_sequencer_if #(.CNT_W(4))  bus1 ();

  fetch_sequencer #(.IR_RESET(16'h0000), .LOW_FIRST(1'b1), .CNT_W(16)) dut0 (
    .Clock (clk),
    .Reset (rst_n0),
    .bus   (bus0)
  );

  fetch_sequencer #(.IR_RESET(16'h0000), .LOW_FIRST(1'b0), .CNT_W(4)) dut1 (
    .Clock (clk),
    .Reset (rst_n1),
    .bus   (bus1)
  );

  assign bus0.Start      = start[0];
  assign bus0.Stall      = stall[0];
  assign bus0.Ack        = ack[0];
  assign bus0.BranchLoad = brl[0];
  assign bus0.MemData    = mem[pc[0]];
  assign bus1.Start      = start[1];
  assign bus1.Stall      = stall[1];
  assign bus1.Ack        = ack[1];
  assign bus1.BranchLoad = brl[1];
  assign bus1.MemData    = mem[pc[1]];

  assign reg_sel[0]  = bus0.ARF_RegSel;
  assign fun_sel[0]  = bus0.ARF_FunSel;
  assign outd_sel[0] = bus0.ARF_OutDSel;
  assign mem_cs[0]   = bus0.Mem_CS;
  assign mem_wr[0]   = bus0.Mem_WR;
  assign ir[0]       = bus0.IR;
  assign ir_valid[0] = bus0.IRValid;
  assign busy[0]     = bus0.Busy;
  assign fc[0]       = bus0.FetchCount;
  assign reg_sel[1]  = bus1.ARF_RegSel;
  assign fun_sel[1]  = bus1.ARF_FunSel;
  assign outd_sel[1] = bus1.ARF_OutDSel;
  assign mem_cs[1]   = bus1.Mem_CS;
  assign mem_wr[1]   = bus1.Mem_WR;
  assign ir[1]       = bus1.IR;
  assign ir_valid[1] = bus1.IRValid;
  assign busy[1]     = bus1.Busy;
  assign fc[1]       = {12'h000, bus1.FetchCount};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the register file's PC: reacts to RegSel/FunSel on each edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pc_set[i]) begin
        pc[i] <= pc_set_val[i];
      end else if (!reg_sel[i][2]) begin
        case (fun_sel[i])
          3'b001:  pc[i] <= pc[i] + 16'd1;
          3'b010:  pc[i] <= i_bus;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: compares each newly presented instruction.
  always @(negedge clk) begin
    exp_t e;
    if (ir_valid[0] === 1'b1 && prev_valid[0] !== 1'b1) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb0_unexpected: got IR %0h, expected no instruction", ir[0]);
      end else begin
        e = exp_q0.pop_front();
        checkOutput("sb0_ir", {16'h0, ir[0]}, {16'h0, e.ir});
        checkOutput("sb0_pc", {16'h0, pc[0]}, {16'h0, e.pc});
        checkOutput("sb0_cnt", {16'h0, fc[0]}, {16'h0, e.cnt});
      end
    end
    if (ir_valid[1] === 1'b1 && prev_valid[1] !== 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb1_unexpected: got IR %0h, expected no instruction", ir[1]);
      end else begin
        e = exp_q1.pop_front();
        checkOutput("sb1_ir", {16'h0, ir[1]}, {16'h0, e.ir});
        checkOutput("sb1_pc", {16'h0, pc[1]}, {16'h0, e.pc});
        checkOutput("sb1_cnt", {16'h0, fc[1]}, {16'h0, e.cnt});
      end
    end
    prev_valid[0] = ir_valid[0];
    prev_valid[1] = ir_valid[1];
  end

  task automatic set_pc(input int i, input logic [15:0] v);
    @(negedge clk);
    pc_set_val[i] = v;
    pc_set[i] = 1'b1;
    @(negedge clk);
    pc_set[i] = 1'b0;
  endtask

  task automatic applyStimulus(input int i, input logic s, input logic st,
                               input logic a, input logic b);
    start[i] = s;
    stall[i] = st;
    ack[i]   = a;
    brl[i]   = b;
  endtask

  task automatic push_exp(input int i, input logic [15:0] e_ir,
                          input logic [15:0] e_pc, input logic [15:0] e_cnt);
    exp_t e;
    e.ir = e_ir;
    e.pc = e_pc;
    e.cnt = e_cnt;
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Start, two fetch cycles, valid, then acknowledge back to idle.
  task automatic fetch_and_ack(input int i);
    @(negedge clk); applyStimulus(i, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); applyStimulus(i, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_bus = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h5A ^ 8'(a);
    mem[16'h0010] = 8'hCD;
    mem[16'h0011] = 8'hAB;
    mem[16'h0020] = 8'h34;
    mem[16'h0021] = 8'h99;
    for (int i = 0; i < 2; i++) begin
      pc[i] = 16'h0000;
      pc_set[i] = 1'b0;
      pc_set_val[i] = 16'h0000;
      prev_valid[i] = 1'b0;
      applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    #12;
    checkOutput("rst_ir", {16'h0, ir[0]}, 32'h0);
    checkOutput("rst_valid", {31'h0, ir_valid[0]}, 32'h0);
    checkOutput("rst_cnt", {16'h0, fc[0]}, 32'h0);
    checkOutput("rst_regsel", {29'h0, reg_sel[0]}, 32'h7);
    checkOutput("rst_memcs", {31'h0, mem_cs[0]}, 32'h1);
    checkOutput("rst_busy1", {31'h0, busy[1]}, 32'h0);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;

    // Plain low-first fetch from 0x0010.
    set_pc(0, 16'h0010);
    push_exp(0, 16'hABCD, 16'h0012, 16'd1);
    @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("f1_regsel", {29'h0, reg_sel[0]}, 32'h3);
    checkOutput("f1_funsel", {29'h0, fun_sel[0]}, 32'h1);
    checkOutput("f1_memcs", {31'h0, mem_cs[0]}, 32'h0);
    checkOutput("f1_memwr", {31'h0, mem_wr[0]}, 32'h0);
    checkOutput("f1_outdsel", {30'h0, outd_sel[0]}, 32'h0);
    checkOutput("f1_busy", {31'h0, busy[0]}, 32'h1);
    @(negedge clk);
    checkOutput("f2_regsel", {29'h0, reg_sel[0]}, 32'h3);
    checkOutput("f2_funsel", {29'h0, fun_sel[0]}, 32'h1);
    checkOutput("f2_valid", {31'h0, ir_valid[0]}, 32'h0);
    @(negedge clk);
    checkOutput("v_valid", {31'h0, ir_valid[0]}, 32'h1);
    checkOutput("v_busy", {31'h0, busy[0]}, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ack_valid", {31'h0, ir_valid[0]}, 32'h0);

    // Same fetch with three stalled cycles in the second byte.
    set_pc(0, 16'h0010);
    push_exp(0, 16'hABCD, 16'h0012, 16'd2);
    @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall_memcs", {31'h0, mem_cs[0]}, 32'h1);
      checkOutput("stall_regsel", {29'h0, reg_sel[0]}, 32'h7);
      checkOutput("stall_pc", {16'h0, pc[0]}, 32'h0011);
      checkOutput("stall_valid", {31'h0, ir_valid[0]}, 32'h0);
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("unstall_memcs", {31'h0, mem_cs[0]}, 32'h0);
    @(negedge clk);
    checkOutput("stall_v_valid", {31'h0, ir_valid[0]}, 32'h1);

    // Branch wins over a simultaneous ack.
    i_bus = 16'h0200;
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_regsel", {29'h0, reg_sel[0]}, 32'h3);
    checkOutput("br_funsel", {29'h0, fun_sel[0]}, 32'h2);
    checkOutput("br_valid", {31'h0, ir_valid[0]}, 32'h0);
    checkOutput("br_busy", {31'h0, busy[0]}, 32'h1);
    @(negedge clk);
    checkOutput("br_pc", {16'h0, pc[0]}, 32'h0200);
    checkOutput("br_idle_busy", {31'h0, busy[0]}, 32'h0);
    checkOutput("br_idle_regsel", {29'h0, reg_sel[0]}, 32'h7);
    checkOutput("br_cnt", {16'h0, fc[0]}, 32'h2);

    // Asynchronous reset in the middle of the second byte.
    set_pc(0, 16'h0020);
    @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mid_ir", {16'h0, ir[0]}, 32'hAB34);
    rst_n0 = 1'b0;
    #1;
    checkOutput("midrst_ir", {16'h0, ir[0]}, 32'h0);
    checkOutput("midrst_valid", {31'h0, ir_valid[0]}, 32'h0);
    checkOutput("midrst_regsel", {29'h0, reg_sel[0]}, 32'h7);
    checkOutput("midrst_cnt", {16'h0, fc[0]}, 32'h0);
    checkOutput("midrst_pc", {16'h0, pc[0]}, 32'h0021);
    @(negedge clk);
    rst_n0 = 1'b1;

    // High-first instance; Start during VALID must not queue a fetch.
    set_pc(1, 16'h0010);
    push_exp(1, 16'hCDAB, 16'h0012, 16'd1);
    @(negedge clk); applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_valid", {31'h0, ir_valid[1]}, 32'h1);
    checkOutput("hold_busy", {31'h0, busy[1]}, 32'h0);
    checkOutput("hold_cnt", {16'h0, fc[1]}, 32'h1);
    @(negedge clk);
    checkOutput("hold_ir", {16'h0, ir[1]}, 32'hCDAB);
    checkOutput("hold_pc", {16'h0, pc[1]}, 32'h0012);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("noqueue_busy", {31'h0, busy[1]}, 32'h0);
    checkOutput("noqueue_cnt", {16'h0, fc[1]}, 32'h1);

    // Fifteen more fetches take the 4-bit counter round to zero.
    for (int k = 2; k <= 16; k++) begin
      set_pc(1, 16'h0010);
      push_exp(1, 16'hCDAB, 16'h0012, 16'(k % 16));
      fetch_and_ack(1);
    end
    checkOutput("wrap_cnt", {16'h0, fc[1]}, 32'h0);

    @(negedge clk);
    checkOutput("sb0_drain", exp_q0.size(), 32'h0);
    checkOutput("sb1_drain", exp_q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
